// File: rtl/lsu_pkg.sv
// Shared RV32I load/store width codes, FSM state type and request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // 1 when the request is illegal for its direction or misaligned for its width.
  function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic legal;
    logic mis;
    case (f3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !we;
      default:          legal = 1'b0;
    endcase
    mis = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return !legal || mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a RAM word and extends it per funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'd0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between a core request port and a byte-lane word RAM.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic [3:0]  mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_result;

  lsu_load_align u_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .result  (ld_result)
  );

  // Store lane placement is computed from the live request so strobes are ready at ISSUE.
  always_comb begin
    case (req_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = '0;
    mem_read_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          if (req_bad(req_we, req_funct3, req_addr[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            mem_read_d  = !req_we;
            mem_write_d = req_we ? st_strb : 4'b0000;
            mem_wdata_d = st_data;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = ld_result;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= '0;
      mem_read_q  <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_wdata_q;

endmodule
